// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline control: opcodes, field slices,
// sequencer state encoding and operand-usage decode helpers.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 4;

  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RC_LSB = 8;
  localparam int unsigned RA_LSB = 4;
  localparam int unsigned RB_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'b0000,
    OP_HALT  = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_CMP   = 4'b0111,
    OP_BN    = 4'b1001,
    OP_BZ    = 4'b1011,
    OP_LOAD  = 4'b1101,
    OP_STORE = 4'b1110
  } opcode_t;

  localparam logic CPU_IDLE = 1'b0;
  localparam logic CPU_EXEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_W-1:0] rc_of(input logic [INSTR_W-1:0] instr);
    return instr[RC_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] ra_of(input logic [INSTR_W-1:0] instr);
    return instr[RA_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rb_of(input logic [INSTR_W-1:0] instr);
    return instr[RB_LSB +: REG_W];
  endfunction

  // Only ADD and LOAD write rC; CMP updates flags only.
  function automatic logic is_writer(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_LOAD);
  endfunction

  function automatic logic reads_ra(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_CMP) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic reads_rb(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_CMP);
  endfunction

  // STORE uses rC as its data source.
  function automatic logic reads_rc(input logic [OP_W-1:0] op);
    return (op == OP_STORE);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-sequencer bundle: stage instructions and flags in, control strobes and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import cpu_pkg::*;

  logic               start;
  logic [INSTR_W-1:0] id_instr;
  logic [INSTR_W-1:0] ex_instr;
  logic [INSTR_W-1:0] mem_instr;
  logic               zf;
  logic               nf;

  logic               cpu_state;
  logic               pc_we;
  logic               ifid_we;
  logic               ifid_flush;
  logic               idex_bubble;
  logic               branch_taken;
  logic               halted;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output start, id_instr, ex_instr, mem_instr, zf, nf,
    input  cpu_state, pc_we, ifid_we, ifid_flush, idex_bubble, branch_taken, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  start, id_instr, ex_instr, mem_instr, zf, nf,
    output cpu_state, pc_we, ifid_we, ifid_flush, idex_bubble, branch_taken, halted,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// RAW hazard check: any register read by the ID instruction that an EX or MEM writer targets.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               stall
);

  logic [OP_W-1:0] id_op;
  logic            ex_hit;
  logic            mem_hit;
  logic            unused_src_fields;

  function automatic logic src_hits(input logic [INSTR_W-1:0] instr,
                                    input logic [REG_W-1:0]   dst);
    logic [OP_W-1:0] op;
    op = op_of(instr);
    return (reads_ra(op) && (ra_of(instr) == dst)) ||
           (reads_rb(op) && (rb_of(instr) == dst)) ||
           (reads_rc(op) && (rc_of(instr) == dst));
  endfunction

  // WB needs no check: the register file writes before it reads.
  always_comb begin
    id_op   = op_of(id_instr);
    ex_hit  = is_writer(op_of(ex_instr))  && src_hits(id_instr, rc_of(ex_instr));
    mem_hit = is_writer(op_of(mem_instr)) && src_hits(id_instr, rc_of(mem_instr));
    stall   = (id_op != OP_NOP) && (ex_hit || mem_hit);
  end

  assign unused_src_fields = ^{ex_instr[RC_LSB-1:0], mem_instr[RC_LSB-1:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: run/drain/halt FSM, branch resolution in EX, RAW stall control
// and saturating stall/flush counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 3
)(
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic               stall_c;
  logic               take_c;
  logic               stall_inc_c;
  logic               flush_inc_c;
  logic [OP_W-1:0]    ex_op_c;
  logic [OP_W-1:0]    id_op_c;

  logic cpu_state_c, pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c, branch_taken_c, halted_c;

  hazard_detect u_hazard (
    .id_instr  (bus.id_instr),
    .ex_instr  (bus.ex_instr),
    .mem_instr (bus.mem_instr),
    .stall     (stall_c)
  );

  assign ex_op_c = op_of(bus.ex_instr);
  assign id_op_c = op_of(bus.id_instr);
  assign take_c  = ((ex_op_c == OP_BZ) && bus.zf) || ((ex_op_c == OP_BN) && bus.nf);

  // Next-state and control decode; a taken branch outranks both stall and HALT.
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    cpu_state_c    = CPU_IDLE;
    pc_we_c        = 1'b0;
    ifid_we_c      = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    branch_taken_c = 1'b0;
    halted_c       = 1'b0;
    stall_inc_c    = 1'b0;
    flush_inc_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        cpu_state_c = CPU_EXEC;
        if (take_c) begin
          branch_taken_c = 1'b1;
          ifid_flush_c   = 1'b1;
          idex_bubble_c  = 1'b1;
          pc_we_c        = 1'b1;
          flush_inc_c    = 1'b1;
        end else if (stall_c) begin
          idex_bubble_c  = 1'b1;
          stall_inc_c    = 1'b1;
        end else if (id_op_c == OP_HALT) begin
          ifid_flush_c   = 1'b1;
          ifid_we_c      = 1'b1;
          drain_d        = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d        = ST_DRAIN;
        end else begin
          pc_we_c        = 1'b1;
          ifid_we_c      = 1'b1;
        end
      end
      ST_DRAIN: begin
        cpu_state_c  = CPU_EXEC;
        ifid_flush_c = 1'b1;
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      ST_HALTED: begin
        halted_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.cpu_state    = cpu_state_c;
  assign bus.pc_we        = pc_we_c;
  assign bus.ifid_we      = ifid_we_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_bubble  = idex_bubble_c;
  assign bus.branch_taken = branch_taken_c;
  assign bus.halted       = halted_c;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences for HALT drain and
// reset-in-drain, then randomized cycles checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int          DRAIN = 3;

  // ctl order: {cpu_state, pc_we, ifid_we, ifid_flush, idex_bubble, branch_taken, halted}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_RUN   = 7'b1110000;
  localparam logic [6:0] C_STALL = 7'b1000100;
  localparam logic [6:0] C_TAKE  = 7'b1101110;
  localparam logic [6:0] C_HALT  = 7'b1011000;
  localparam logic [6:0] C_DRAIN = 7'b1001000;
  localparam logic [6:0] C_DONE  = 7'b0000001;

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] id;
    logic [15:0] ex;
    logic [15:0] mem;
    logic        z;
    logic        n;
    logic [6:0]  ctl;
    int          s;
    int          f;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int         m_mode  = 0;
  int         m_drain = 0;
  int         m_stall = 0;
  int         m_flush = 0;
  logic [6:0] m_ctl;
  int         m_s, m_f;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fop(input logic [15:0] i);  return (int'(i) >> 12) & 15; endfunction
  function automatic int frc(input logic [15:0] i);  return (int'(i) >> 8) & 15;  endfunction
  function automatic bit writes(input int op);       return (op == 2) || (op == 13); endfunction

  function automatic bit ref_hazard(input logic [15:0] id, input logic [15:0] ex, input logic [15:0] mem);
    int srcs[$];
    int op = fop(id);
    int ra = (int'(id) >> 4) & 15;
    int rb = int'(id) & 15;
    bit h = 0;
    if (op == 2 || op == 7) srcs = '{ra, rb};
    else if (op == 13)      srcs = '{ra};
    else if (op == 14)      srcs = '{ra, frc(id)};
    foreach (srcs[k]) begin
      if (writes(fop(ex))  && srcs[k] == frc(ex))  h = 1;
      if (writes(fop(mem)) && srcs[k] == frc(mem)) h = 1;
    end
    return h;
  endfunction

  // Reference: outputs for the current mode, then the mode/counters after the clock edge.
  task automatic model_cycle(input logic r, input logic st, input logic [15:0] id,
                             input logic [15:0] ex, input logic [15:0] mem, input logic z, input logic n);
    bit take = (fop(ex) == 11 && z) || (fop(ex) == 9 && n);
    m_s = m_stall;
    m_f = m_flush;
    case (m_mode)
      0: begin m_ctl = C_IDLE; if (st) m_mode = 1; end
      1: begin
        if (take) begin
          m_ctl = C_TAKE;
          if (m_flush < 65535) m_flush++;
        end else if (ref_hazard(id, ex, mem)) begin
          m_ctl = C_STALL;
          if (m_stall < 65535) m_stall++;
        end else if (fop(id) == 1) begin
          m_ctl = C_HALT; m_mode = 2; m_drain = 0;
        end else m_ctl = C_RUN;
      end
      2: begin
        m_ctl = C_DRAIN;
        m_drain++;
        if (m_drain == DRAIN) m_mode = 3;
      end
      default: m_ctl = C_DONE;
    endcase
    if (!r) begin m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0; end
  endtask

  task automatic apply(input logic r, input logic st, input logic [15:0] id,
                       input logic [15:0] ex, input logic [15:0] mem, input logic z, input logic n);
    @(negedge clk);
    reset = r; bus.start = st; bus.id_instr = id; bus.ex_instr = ex; bus.mem_instr = mem;
    bus.zf = z; bus.nf = n;
    #1;
    model_cycle(r, st, id, ex, mem, z, n);
  endtask

  task automatic check(input string name, input logic [6:0] ctl, input int s, input int f);
    logic [6:0] got;
    got = {bus.cpu_state, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
           bus.branch_taken, bus.halted};
    checks++;
    if (got !== ctl || int'(bus.stall_cnt) != s || int'(bus.flush_cnt) != f) begin
      errors++;
      $display("FAIL %s @%0t: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
               name, $time, got, bus.stall_cnt, bus.flush_cnt, ctl, s, f);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic st, input logic [15:0] id,
                               input logic [15:0] ex, input logic [15:0] mem, input logic z,
                               input logic n, input logic [6:0] c, input int s, input int f);
    vec_t v;
    v = '{r, st, id, ex, mem, z, n, c, s, f};
    return v;
  endfunction

  function automatic logic [15:0] rand_instr();
    int ops[8];
    int op;
    ops = '{0, 1, 2, 7, 9, 11, 13, 14};
    op  = ops[$urandom_range(0, 7)];
    if (op == 1 && $urandom_range(0, 15) != 0) op = 2;
    return 16'((op << 12) | (int'($urandom_range(0, 3)) << 8) |
               (int'($urandom_range(0, 3)) << 4) | int'($urandom_range(0, 3)));
  endfunction

  initial begin
    vec_t vecs[13];
    vecs[0]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, C_IDLE,  0, 0);
    vecs[1]  = mkv(1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, C_IDLE,  0, 0);
    vecs[2]  = mkv(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, C_RUN,   0, 0);
    vecs[3]  = mkv(1, 0, 16'h2435, 16'h2312, 16'h0000, 0, 0, C_STALL, 0, 0);
    vecs[4]  = mkv(1, 0, 16'h2435, 16'h0000, 16'h2312, 0, 0, C_STALL, 1, 0);
    vecs[5]  = mkv(1, 0, 16'h2435, 16'h0000, 16'h0000, 0, 0, C_RUN,   2, 0);
    vecs[6]  = mkv(1, 0, 16'h2435, 16'hB010, 16'h2312, 1, 0, C_TAKE,  2, 0);
    vecs[7]  = mkv(1, 0, 16'h2435, 16'h9010, 16'h0000, 1, 0, C_RUN,   2, 1);
    vecs[8]  = mkv(1, 0, 16'h2312, 16'hB010, 16'h0000, 0, 1, C_RUN,   2, 1);
    vecs[9]  = mkv(1, 0, 16'h1000, 16'h9010, 16'h0000, 0, 1, C_TAKE,  2, 1);
    vecs[10] = mkv(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, C_RUN,   2, 2);
    vecs[11] = mkv(1, 0, 16'hE310, 16'h0000, 16'hD300, 0, 0, C_STALL, 2, 2);
    vecs[12] = mkv(1, 0, 16'h2435, 16'h0000, 16'h7300, 0, 0, C_RUN,   3, 2);

    reset = 1'b0; bus.start = 1'b0; bus.id_instr = '0; bus.ex_instr = '0; bus.mem_instr = '0;
    bus.zf = 1'b0; bus.nf = 1'b0;
    apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].z, vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].s, vecs[i].f);
    end

    // HALT drains for three cycles, then halted is sticky and start is ignored.
    apply(1, 0, 16'h1000, 16'h0000, 16'h0000, 0, 0); check("halt_enter", C_HALT, 3, 2);
    for (int k = 0; k < DRAIN; k++) begin
      apply(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      check($sformatf("drain%0d", k), C_DRAIN, 3, 2);
    end
    apply(1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0); check("halted", C_DONE, 3, 2);
    apply(1, 0, 16'h2435, 16'hB010, 16'h2312, 1, 1); check("halted_start", C_DONE, 3, 2);
    apply(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check("halted_hold", C_DONE, 3, 2);

    // Reset asserted while draining returns to IDLE with cleared counters.
    apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check("rst_from_halted", C_DONE, 3, 2);
    apply(1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0); check("idle_after_rst", C_IDLE, 0, 0);
    apply(1, 0, 16'h2435, 16'h2312, 16'h0000, 0, 0); check("stall2", C_STALL, 0, 0);
    apply(1, 0, 16'h1000, 16'h0000, 16'h0000, 0, 0); check("halt2", C_HALT, 1, 0);
    apply(0, 1, 16'h2435, 16'hB010, 16'h2312, 1, 0); check("drain_rst", C_DRAIN, 1, 0);
    apply(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check("idle_post_drain", C_IDLE, 0, 0);

    // Random phase: reference model tracks from a fresh reset.
    apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      apply(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0), rand_instr(),
            rand_instr(), rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rand", m_ctl, m_s, m_f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
